// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared widths, alu_16b op encodings and EX control bundle
// for the ID/EX stage register and its hazard/forwarding unit.
package id_ex_stage_reg_pkg;

    localparam int W_DEF     = 16;
    localparam int RW_DEF    = 3;
    localparam int CNT_W_DEF = 16;
    localparam int OP_W      = 4;

    typedef enum logic [OP_W-1:0] {
        OP_SHL  = 4'b0000,
        OP_SHR  = 4'b0001,
        OP_ROL  = 4'b0010,
        OP_ROR  = 4'b0011,
        OP_ADD  = 4'b0100,
        OP_SUB  = 4'b0101,
        OP_AND  = 4'b0110,
        OP_OR   = 4'b0111,
        OP_BTR  = 4'b1000,
        OP_SLBI = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_ID,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_sel_e;

    typedef struct packed {
        logic valid;
        logic wr_en;
        logic mem_rd;
    } ex_ctrl_t;

    // A bubble only needs its control bits cleared; data fields are left as-is.
    localparam ex_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_hazard_fwd_unit.sv
// hazard_fwd_unit: combinational RAW dependency check, operand forwarding and hazard stall.
// ID_EX_FWD_EN selects forwarding (load-use stall only); otherwise stall on EX/MEM producers.
module hazard_fwd_unit
    import id_ex_stage_reg_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          id_rs1_used_i,
    input  logic          id_rs2_used_i,
    input  logic [RW-1:0] id_rs1_i,
    input  logic [RW-1:0] id_rs2_i,
    input  logic [W-1:0]  id_in1_i,
    input  logic [W-1:0]  id_in2_i,
    input  logic          ex_valid_i,
    input  logic          ex_wr_en_i,
    input  logic          ex_mem_rd_i,
    input  logic [RW-1:0] ex_rd_i,
    input  logic [W-1:0]  ex_alu_out_i,
    input  logic          mem_valid_i,
    input  logic          mem_wr_en_i,
    input  logic [RW-1:0] mem_rd_i,
    input  logic [W-1:0]  mem_data_i,
    input  logic          wb_valid_i,
    input  logic          wb_wr_en_i,
    input  logic [RW-1:0] wb_rd_i,
    input  logic [W-1:0]  wb_data_i,
    output logic [W-1:0]  fwd_in1_o,
    output logic [W-1:0]  fwd_in2_o,
    output logic          hazard_stall_o
);

    function automatic logic dep(input logic used, input logic [RW-1:0] src,
                                 input logic pv, input logic pwe, input logic [RW-1:0] prd);
        return used & pv & pwe & (src == prd);
    endfunction

    logic ex1, ex2, mem1, mem2;

    assign ex1  = dep(id_rs1_used_i, id_rs1_i, ex_valid_i, ex_wr_en_i, ex_rd_i);
    assign ex2  = dep(id_rs2_used_i, id_rs2_i, ex_valid_i, ex_wr_en_i, ex_rd_i);
    assign mem1 = dep(id_rs1_used_i, id_rs1_i, mem_valid_i, mem_wr_en_i, mem_rd_i);
    assign mem2 = dep(id_rs2_used_i, id_rs2_i, mem_valid_i, mem_wr_en_i, mem_rd_i);

`ifdef ID_EX_FWD_EN
    logic wb1, wb2;
    fwd_sel_e sel1, sel2;

    assign wb1 = dep(id_rs1_used_i, id_rs1_i, wb_valid_i, wb_wr_en_i, wb_rd_i);
    assign wb2 = dep(id_rs2_used_i, id_rs2_i, wb_valid_i, wb_wr_en_i, wb_rd_i);

    // A load in EX has no data yet, so its match falls through and the stall covers it.
    function automatic fwd_sel_e pick(input logic e, input logic m, input logic w);
        return (e & ~ex_mem_rd_i) ? FWD_EX : m ? FWD_MEM : w ? FWD_WB : FWD_ID;
    endfunction

    always_comb begin
        sel1           = pick(ex1, mem1, wb1);
        sel2           = pick(ex2, mem2, wb2);
        fwd_in1_o      = sel1 == FWD_EX  ? ex_alu_out_i :
                         sel1 == FWD_MEM ? mem_data_i   :
                         sel1 == FWD_WB  ? wb_data_i    : id_in1_i;
        fwd_in2_o      = sel2 == FWD_EX  ? ex_alu_out_i :
                         sel2 == FWD_MEM ? mem_data_i   :
                         sel2 == FWD_WB  ? wb_data_i    : id_in2_i;
        hazard_stall_o = ex_mem_rd_i & (ex1 | ex2);
    end
`else
    logic unused_fwd;

    // Regfile writes before read, so WB needs no handling; EX/MEM producers stall.
    assign unused_fwd     = ^{ex_mem_rd_i, ex_alu_out_i, mem_data_i,
                              wb_valid_i, wb_wr_en_i, wb_rd_i, wb_data_i};
    assign fwd_in1_o      = id_in1_i;
    assign fwd_in2_o      = id_in2_i;
    assign hazard_stall_o = ex1 | ex2 | mem1 | mem2;
`endif

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register feeding alu_16b with flush/hold/bubble priority and
// a saturating stall counter. Define ID_EX_FWD_EN to enable EX/MEM/WB operand forwarding.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int RW    = RW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [W-1:0]     id_in1_i,
    input  logic [W-1:0]     id_in2_i,
    input  logic [RW-1:0]    id_rs1_i,
    input  logic [RW-1:0]    id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [OP_W-1:0]  id_op_i,
    input  logic             id_neg1_i,
    input  logic             id_neg2_i,
    input  logic [RW-1:0]    id_rd_i,
    input  logic             id_wr_en_i,
    input  logic             id_mem_rd_i,
    input  logic [W-1:0]     ex_alu_out_i,
    input  logic             mem_valid_i,
    input  logic             mem_wr_en_i,
    input  logic [RW-1:0]    mem_rd_i,
    input  logic [W-1:0]     mem_data_i,
    input  logic             wb_valid_i,
    input  logic             wb_wr_en_i,
    input  logic [RW-1:0]    wb_rd_i,
    input  logic [W-1:0]     wb_data_i,
    input  logic             flush_i,
    input  logic             ex_hold_i,
    output logic             ex_valid_o,
    output logic [W-1:0]     ex_in1_o,
    output logic [W-1:0]     ex_in2_o,
    output logic [OP_W-1:0]  ex_op_o,
    output logic             ex_neg1_o,
    output logic             ex_neg2_o,
    output logic [RW-1:0]    ex_rd_o,
    output logic             ex_wr_en_o,
    output logic             ex_mem_rd_o,
    output logic             stall_id_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ex_ctrl_t         ctrl_q, ctrl_d;
    logic [W-1:0]     in1_q, in1_d, in2_q, in2_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             neg1_q, neg1_d, neg2_q, neg2_d;
    logic [RW-1:0]    rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     fwd_in1, fwd_in2;
    logic             hazard_stall;

    hazard_fwd_unit #(.W(W), .RW(RW)) u_hazard (
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_in1_i       (id_in1_i),
        .id_in2_i       (id_in2_i),
        .ex_valid_i     (ctrl_q.valid),
        .ex_wr_en_i     (ctrl_q.wr_en),
        .ex_mem_rd_i    (ctrl_q.mem_rd),
        .ex_rd_i        (rd_q),
        .ex_alu_out_i   (ex_alu_out_i),
        .mem_valid_i    (mem_valid_i),
        .mem_wr_en_i    (mem_wr_en_i),
        .mem_rd_i       (mem_rd_i),
        .mem_data_i     (mem_data_i),
        .wb_valid_i     (wb_valid_i),
        .wb_wr_en_i     (wb_wr_en_i),
        .wb_rd_i        (wb_rd_i),
        .wb_data_i      (wb_data_i),
        .fwd_in1_o      (fwd_in1),
        .fwd_in2_o      (fwd_in2),
        .hazard_stall_o (hazard_stall)
    );

    assign stall_id_o = ex_hold_i | (id_valid_i & hazard_stall);

    always_comb begin
        ctrl_d = ctrl_q;
        in1_d  = in1_q;
        in2_d  = in2_q;
        op_d   = op_q;
        neg1_d = neg1_q;
        neg2_d = neg2_q;
        rd_d   = rd_q;
        if (flush_i) begin
            ctrl_d = BUBBLE;
        end else if (!ex_hold_i) begin
            if (id_valid_i & hazard_stall) begin
                ctrl_d = BUBBLE;
            end else begin
                ctrl_d = '{valid: id_valid_i, wr_en: id_valid_i & id_wr_en_i,
                           mem_rd: id_valid_i & id_mem_rd_i};
                in1_d  = fwd_in1;
                in2_d  = fwd_in2;
                op_d   = id_op_i;
                neg1_d = id_neg1_i;
                neg2_d = id_neg2_i;
                rd_d   = id_rd_i;
            end
        end
        cnt_d = (stall_id_o && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= BUBBLE;
            in1_q  <= '0;
            in2_q  <= '0;
            op_q   <= '0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            in1_q  <= in1_d;
            in2_q  <= in2_d;
            op_q   <= op_d;
            neg1_q <= neg1_d;
            neg2_q <= neg2_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid_o  = ctrl_q.valid;
    assign ex_wr_en_o  = ctrl_q.wr_en;
    assign ex_mem_rd_o = ctrl_q.mem_rd;
    assign ex_in1_o    = in1_q;
    assign ex_in2_o    = in2_q;
    assign ex_op_o     = op_q;
    assign ex_neg1_o   = neg1_q;
    assign ex_neg2_o   = neg2_q;
    assign ex_rd_o     = rd_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed literal checks plus randomized stimulus against a behavioural
// model of the ID/EX register; follows ID_EX_FWD_EN the same way the design does.
module tb_id_ex_stage_reg;

    localparam int W    = 16;
    localparam int RW   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_rs1_used, id_rs2_used, id_neg1, id_neg2, id_wr_en, id_mem_rd;
    logic [W-1:0] id_in1, id_in2, ex_alu_out, mem_data, wb_data;
    logic [RW-1:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [3:0] id_op;
    logic mem_valid, mem_wr_en, wb_valid, wb_wr_en, flush, ex_hold;
    logic ex_valid, ex_neg1, ex_neg2, ex_wr_en, ex_mem_rd, stall_id;
    logic [W-1:0] ex_in1, ex_in2;
    logic [3:0] ex_op;
    logic [RW-1:0] ex_rd;
    logic [CW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.W(W), .RW(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_in1_i(id_in1), .id_in2_i(id_in2),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_op_i(id_op), .id_neg1_i(id_neg1), .id_neg2_i(id_neg2),
        .id_rd_i(id_rd), .id_wr_en_i(id_wr_en), .id_mem_rd_i(id_mem_rd),
        .ex_alu_out_i(ex_alu_out),
        .mem_valid_i(mem_valid), .mem_wr_en_i(mem_wr_en), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
        .wb_valid_i(wb_valid), .wb_wr_en_i(wb_wr_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .flush_i(flush), .ex_hold_i(ex_hold),
        .ex_valid_o(ex_valid), .ex_in1_o(ex_in1), .ex_in2_o(ex_in2), .ex_op_o(ex_op),
        .ex_neg1_o(ex_neg1), .ex_neg2_o(ex_neg2), .ex_rd_o(ex_rd),
        .ex_wr_en_o(ex_wr_en), .ex_mem_rd_o(ex_mem_rd),
        .stall_id_o(stall_id), .stall_cnt_o(stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the EX slot as plain variables, updated from the priority rules.
    logic m_valid, m_we, m_mr, m_n1, m_n2;
    logic [W-1:0] m_in1, m_in2;
    logic [3:0] m_op;
    logic [RW-1:0] m_rd;
    int m_cnt;

    function automatic logic writes(input logic used, input logic [RW-1:0] src,
                                    input logic v, input logic we, input logic [RW-1:0] rd);
        return used && v && we && src == rd;
    endfunction

    function automatic logic m_hazard();
        logic on_ex  = writes(id_rs1_used, id_rs1, m_valid, m_we, m_rd) ||
                       writes(id_rs2_used, id_rs2, m_valid, m_we, m_rd);
        logic on_mem = writes(id_rs1_used, id_rs1, mem_valid, mem_wr_en, mem_rd) ||
                       writes(id_rs2_used, id_rs2, mem_valid, mem_wr_en, mem_rd);
`ifdef ID_EX_FWD_EN
        return on_ex && m_mr;
`else
        return on_ex || on_mem;
`endif
    endfunction

    function automatic logic m_stall();
        return ex_hold || (id_valid && m_hazard());
    endfunction

    // Newest producer wins: walk EX (non-load), MEM, WB in order, else the regfile value.
    function automatic logic [W-1:0] m_operand(input logic used, input logic [RW-1:0] src,
                                               input logic [W-1:0] regval);
        logic [W-1:0] val [3];
        logic hit [3];
        hit[0] = writes(used, src, m_valid && !m_mr, m_we, m_rd);
        hit[1] = writes(used, src, mem_valid, mem_wr_en, mem_rd);
        hit[2] = writes(used, src, wb_valid, wb_wr_en, wb_rd);
        val[0] = ex_alu_out;
        val[1] = mem_data;
        val[2] = wb_data;
`ifdef ID_EX_FWD_EN
        for (int k = 0; k < 3; k++)
            if (hit[k]) return val[k];
`endif
        return regval;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_we <= 0; m_mr <= 0; m_n1 <= 0; m_n2 <= 0;
            m_in1 <= '0; m_in2 <= '0; m_op <= '0; m_rd <= '0; m_cnt <= 0;
        end else begin
            if (m_stall() && m_cnt < CMAX) m_cnt <= m_cnt + 1;
            if (flush || (!ex_hold && id_valid && m_hazard())) begin
                m_valid <= 0; m_we <= 0; m_mr <= 0;
            end else if (!ex_hold) begin
                m_valid <= id_valid;
                m_we    <= id_valid && id_wr_en;
                m_mr    <= id_valid && id_mem_rd;
                m_in1   <= m_operand(id_rs1_used, id_rs1, id_in1);
                m_in2   <= m_operand(id_rs2_used, id_rs2, id_in2);
                m_op    <= id_op;
                m_n1    <= id_neg1;
                m_n2    <= id_neg2;
                m_rd    <= id_rd;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ex_valid", ex_valid, m_valid);
            check("ex_wr_en", ex_wr_en, m_we);
            check("ex_mem_rd", ex_mem_rd, m_mr);
            check("stall_id", stall_id, m_stall());
            check("stall_cnt", stall_cnt, m_cnt);
            if (m_valid) begin
                check("ex_in1", ex_in1, m_in1);
                check("ex_in2", ex_in2, m_in2);
                check("ex_op", ex_op, m_op);
                check("ex_neg", {ex_neg1, ex_neg2}, {m_n1, m_n2});
                check("ex_rd", ex_rd, m_rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_in1 = '0; id_in2 = '0; id_rs1 = '0; id_rs2 = '0;
        id_rs1_used = 0; id_rs2_used = 0; id_op = '0; id_neg1 = 0; id_neg2 = 0;
        id_rd = '0; id_wr_en = 0; id_mem_rd = 0; ex_alu_out = '0;
        mem_valid = 0; mem_wr_en = 0; mem_rd = '0; mem_data = '0;
        wb_valid = 0; wb_wr_en = 0; wb_rd = '0; wb_data = '0;
        flush = 0; ex_hold = 0;
    endtask

    task automatic set_id(input logic v, input logic [RW-1:0] rs1, input logic u1,
                          input logic [RW-1:0] rs2, input logic u2,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          input logic [RW-1:0] rd, input logic we, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_in1 = a; id_in2 = b; id_op = op; id_rd = rd; id_wr_en = we; id_mem_rd = mr;
        id_neg1 = 0; id_neg2 = 0;
    endtask

    task automatic rand_inputs();
        id_valid = $urandom_range(0, 3) != 0;
        id_in1 = W'($urandom); id_in2 = W'($urandom);
        id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
        id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
        id_op = 4'($urandom); id_neg1 = 1'($urandom); id_neg2 = 1'($urandom);
        id_rd = RW'($urandom_range(0, 3));
        id_wr_en = $urandom_range(0, 3) != 0; id_mem_rd = $urandom_range(0, 2) == 0;
        ex_alu_out = W'($urandom);
        mem_valid = 1'($urandom); mem_wr_en = 1'($urandom);
        mem_rd = RW'($urandom_range(0, 3)); mem_data = W'($urandom);
        wb_valid = 1'($urandom); wb_wr_en = 1'($urandom);
        wb_rd = RW'($urandom_range(0, 3)); wb_data = W'($urandom);
        flush = $urandom_range(0, 7) == 0;
        ex_hold = $urandom_range(0, 5) == 0;
    endtask

    int base;

    initial begin
`ifdef ID_EX_FWD_EN
        base = 0;
`else
        base = 2;
`endif
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ex_valid, 0);
        check("rst_cnt", stall_cnt, 0);
        rst_n = 1;
        // Independent ADD r1 = r2 + r3
        set_id(1, 2, 1, 3, 1, 16'h0003, 16'h0004, 4'b0100, 1, 1, 0);
        #1 check("add_stall", stall_id, 0);
        tick();
        check("add_valid", ex_valid, 1);
        check("add_in1", ex_in1, 16'h0003);
        check("add_in2", ex_in2, 16'h0004);
        check("add_op", ex_op, 4'b0100);
        // Consumer of r1 while its producer sits in EX
        set_id(1, 1, 1, 6, 0, 16'h0055, 16'h0007, 4'b0100, 2, 1, 0);
        ex_alu_out = 16'h1234;
`ifdef ID_EX_FWD_EN
        #1 check("exfwd_stall", stall_id, 0);
        tick();
        check("exfwd_valid", ex_valid, 1);
        check("exfwd_in1", ex_in1, 16'h1234);
`else
        #1 check("raw_stall_ex", stall_id, 1);
        tick();
        check("raw_bubble1", ex_valid, 0);
        mem_valid = 1; mem_wr_en = 1; mem_rd = 1; mem_data = 16'h1234;
        #1 check("raw_stall_mem", stall_id, 1);
        tick();
        check("raw_bubble2", ex_valid, 0);
        mem_valid = 0; wb_valid = 1; wb_wr_en = 1; wb_rd = 1; wb_data = 16'h1234;
        #1 check("raw_stall_wb", stall_id, 0);
        tick();
        check("raw_valid", ex_valid, 1);
        check("raw_in1", ex_in1, 16'h0055);
`endif
        idle();
        // Load to r5, then a consumer of r5
        set_id(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'b0100, 5, 1, 1);
        tick();
        check("load_mem_rd", ex_mem_rd, 1);
        set_id(1, 5, 1, 0, 0, 16'h0777, 16'h0001, 4'b0100, 6, 1, 0);
        #1 check("lu_stall", stall_id, 1);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_cnt", stall_cnt, base + 1);
        #1 check("lu_release", stall_id, 0);
        tick();
        check("lu_valid", ex_valid, 1);
        check("lu_in1", ex_in1, 16'h0777);
        // flush + hold + valid ID together
        set_id(1, 0, 0, 0, 0, 16'h0999, 16'h0000, 4'b0101, 3, 1, 0);
        flush = 1; ex_hold = 1;
        #1 check("fh_stall", stall_id, 1);
        tick();
        check("fh_bubble", ex_valid, 0);
        check("fh_cnt", stall_cnt, base + 2);
        flush = 0; ex_hold = 0;
        set_id(1, 0, 0, 0, 0, 16'h0BEE, 16'h0000, 4'b0101, 4, 1, 0);
        tick();
        check("cap_in1", ex_in1, 16'h0BEE);
        ex_hold = 1;
        set_id(1, 0, 0, 0, 0, 16'h0DAD, 16'h0000, 4'b0110, 7, 1, 0);
        tick();
        check("hold_in1", ex_in1, 16'h0BEE);
        check("hold_rd", ex_rd, 4);
        check("hold_op", ex_op, 4'b0101);
        check("hold_cnt", stall_cnt, base + 3);
        ex_hold = 0;
        // r4 produced in EX, MEM and WB at once
        set_id(1, 0, 0, 4, 1, 16'h0000, 16'h0111, 4'b0100, 2, 1, 0);
        ex_alu_out = 16'hAAAA;
        mem_valid = 1; mem_wr_en = 1; mem_rd = 4; mem_data = 16'hBBBB;
        wb_valid = 1; wb_wr_en = 1; wb_rd = 4; wb_data = 16'hCCCC;
`ifdef ID_EX_FWD_EN
        #1 check("tri_stall", stall_id, 0);
        tick();
        check("tri_in2", ex_in2, 16'hAAAA);
`else
        #1 check("tri_stall", stall_id, 1);
        tick();
        check("tri_bubble", ex_valid, 0);
`endif
        // Counter saturation under a long downstream hold
        idle();
        ex_hold = 1;
        repeat (20) tick();
        check("cnt_sat", stall_cnt, CMAX);
        // Asynchronous reset with a valid instruction in EX
        ex_hold = 0;
        set_id(1, 0, 0, 0, 0, 16'h4242, 16'h0000, 4'b0100, 3, 1, 0);
        tick();
        check("pre_rst_valid", ex_valid, 1);
        rst_n = 0;
        #1;
        check("async_valid", ex_valid, 0);
        check("async_in1", ex_in1, 0);
        check("async_wr_en", ex_wr_en, 0);
        check("async_cnt", stall_cnt, 0);
        tick();
        rst_n = 1;
        // Randomized traffic with occasional mid-cycle resets
        repeat (3000) begin
            tick();
            rand_inputs();
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 0;
                #2 rst_n = 1;
            end
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
